// File: rtl/shifter_arbiter_pkg.sv
// Shared definitions for the shifter_arbiter slice: FSM state encoding,
// shifter datapath widths and the saturating grant-counter helper.
package shifter_arbiter_pkg;

  localparam int SHIFT_DATA_W = 32;
  localparam int SHIFT_AMT_W  = 5;
  localparam int PERF_CNT_W   = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (v == {PERF_CNT_W{1'b1}}) ? v : v + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/shifter_arbiter_rr_arbiter_nreq.sv
// rr_arbiter_nreq: purely combinational round-robin pick. Searches the
// request vector starting at ptr, wrapping at NREQ, and returns a one-hot
// grant plus the encoded winner index. The pointer register is owned by
// the caller.
module rr_arbiter_nreq
  import shifter_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  int             j;
  logic [IDW-1:0] jj;
  logic           found;

  // First requester at or after ptr (with wrap-around) wins while enabled.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end else begin
        j = j;
      end
      jj = IDW'(j);
      if (en && !found && req[jj]) begin
        gnt[jj] = 1'b1;
        idx     = jj;
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/shifter_arbiter.sv
// shifter_arbiter: shares one external barrel shifter between NREQ
// requesters. IDLE grants round-robin and registers the winner's operands
// onto the shifter inputs, EXEC captures the shifter result, RESP holds a
// tagged response until the consumer takes it.
// Optional build macro SHIFT_ARB_PERF_EN adds per-requester saturating
// 16-bit grant counters on port perf_cnt.
module shifter_arbiter
  import shifter_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*SHIFT_DATA_W-1:0] req_data,
  input  logic [NREQ*SHIFT_AMT_W-1:0]  req_amt,
  input  logic [NREQ-1:0]              req_lnr,
  output logic [SHIFT_DATA_W-1:0]      sh_d,
  output logic [SHIFT_AMT_W-1:0]       sh_s,
  output logic                         sh_lnr,
  input  logic [SHIFT_DATA_W-1:0]      sh_y,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [SHIFT_DATA_W-1:0]      rsp_data,
  output logic [IDW-1:0]               rsp_id,
`ifdef SHIFT_ARB_PERF_EN
  output logic [NREQ*PERF_CNT_W-1:0]   perf_cnt,
`endif
  output logic                         busy
);

  arb_state_e              state_q, state_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [SHIFT_DATA_W-1:0] sh_d_q, sh_d_d;
  logic [SHIFT_AMT_W-1:0]  sh_s_q, sh_s_d;
  logic                    sh_lnr_q, sh_lnr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [SHIFT_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]          rsp_id_q, rsp_id_d;

  logic                    grant_en;
  logic [NREQ-1:0]         win_gnt;
  logic [IDW-1:0]          win_idx;
  logic                    accept;
  logic [SHIFT_DATA_W-1:0] win_data;
  logic [SHIFT_AMT_W-1:0]  win_amt;
  logic                    win_lnr;

  // Gating with RST keeps req_ready low while reset is held.
  assign grant_en = RST & (state_q == ARB_IDLE);

  rr_arbiter_nreq #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (grant_en),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign accept    = |win_gnt;
  assign req_ready = win_gnt;

  // AND-OR mux of the winner's operands using the one-hot grant.
  always_comb begin
    win_data = '0;
    win_amt  = '0;
    win_lnr  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      win_data = win_data | ({SHIFT_DATA_W{win_gnt[i]}} & req_data[SHIFT_DATA_W*i +: SHIFT_DATA_W]);
      win_amt  = win_amt  | ({SHIFT_AMT_W{win_gnt[i]}}  & req_amt[SHIFT_AMT_W*i +: SHIFT_AMT_W]);
      win_lnr  = win_lnr  | (win_gnt[i] & req_lnr[i]);
    end
  end

  // Next-state and next-output computation for the IDLE/EXEC/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    sh_d_d      = sh_d_q;
    sh_s_d      = sh_s_q;
    sh_lnr_d    = sh_lnr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          sh_d_d   = win_data;
          sh_s_d   = win_amt;
          sh_lnr_d = win_lnr;
          id_d     = win_idx;
          if (win_idx == IDW'(NREQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = win_idx + IDW'(1);
          end
          state_d = ARB_EXEC;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_EXEC: begin
        rsp_data_d  = sh_y;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ARB_RESP;
      end
      ARB_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ARB_IDLE;
        end else begin
          state_d = ARB_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ARB_IDLE;
      end
    endcase
  end

  // Sequencer state and all registered outputs; reset discards any in-flight op.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      sh_d_q      <= '0;
      sh_s_q      <= '0;
      sh_lnr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      sh_d_q      <= sh_d_d;
      sh_s_q      <= sh_s_d;
      sh_lnr_q    <= sh_lnr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign sh_d      = sh_d_q;
  assign sh_s      = sh_s_q;
  assign sh_lnr    = sh_lnr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ARB_IDLE);

`ifdef SHIFT_ARB_PERF_EN
  logic [NREQ-1:0][PERF_CNT_W-1:0] perf_q, perf_d;

  // Each counter bumps on its requester's acceptance and sticks at all-ones.
  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < NREQ; i++) begin
      if (win_gnt[i]) begin
        perf_d[i] = sat_inc(perf_q[i]);
      end else begin
        perf_d[i] = perf_q[i];
      end
    end
  end

  // Grant counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter (NREQ=4, IDW=2). A behavioural
// model tracks the operation phase, round-robin pointer and the expected
// shifted result; directed cases are followed by randomized traffic.
module tb_shifter_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ*5-1:0] req_amt;
  logic [NREQ-1:0]   req_lnr;
  logic [31:0]       sh_d;
  logic [4:0]        sh_s;
  logic              sh_lnr;
  logic [31:0]       sh_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
`ifdef SHIFT_ARB_PERF_EN
  logic [NREQ*16-1:0] perf_cnt;
`endif

  shifter_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_lnr   (req_lnr),
    .sh_d      (sh_d),
    .sh_s      (sh_s),
    .sh_lnr    (sh_lnr),
    .sh_y      (sh_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
`ifdef SHIFT_ARB_PERF_EN
    .perf_cnt  (perf_cnt),
`endif
    .busy      (busy)
  );

  // External logical barrel shifter, zero fill.
  assign sh_y = sh_lnr ? (sh_d << sh_s) : (sh_d >> sh_s);

  always #5 CLK = ~CLK;

  // Requester-side stimulus state.
  bit          rv [NREQ];
  logic [31:0] rd [NREQ];
  logic [4:0]  rs [NREQ];
  bit          rl [NREQ];
  bit          rr_b;

  // Reference model.
  int          m_ptr;
  int          m_phase;      // 0: free, 1: operation just accepted, 2: response held
  bit          m_rsp_valid;
  logic [31:0] m_rsp_data;
  int          m_rsp_id;
  logic [31:0] m_pend_data;
  int          m_pend_id;
  logic [31:0] m_sh_d;
  logic [4:0]  m_sh_s;
  bit          m_sh_lnr;
  int          m_cnt [NREQ];

  int          n_checks = 0;
  int          n_errors = 0;
  int          last_w;
  logic [NREQ-1:0] obs_ready;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr       = 0;
    m_phase     = 0;
    m_rsp_valid = 1'b0;
    m_rsp_data  = 32'd0;
    m_rsp_id    = 0;
    m_pend_data = 32'd0;
    m_pend_id   = 0;
    m_sh_d      = 32'd0;
    m_sh_s      = 5'd0;
    m_sh_lnr    = 1'b0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  function automatic int exp_winner();
    for (int k = 0; k < NREQ; k++) begin
      if (rv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = rv[i];
      req_data[32*i +: 32] = rd[i];
      req_amt[5*i +: 5]   = rs[i];
      req_lnr[i]          = rl[i];
    end
    rsp_ready = rr_b;
  endtask

  // One clock cycle: drive, compare everything against the model, advance the model.
  task automatic tick();
    int w;
    logic [NREQ-1:0] exp_ready;
    drive_inputs();
    #1;
    w = (m_phase == 0) ? exp_winner() : -1;
    exp_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
    obs_ready = req_ready;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("busy",      32'(busy),      32'(m_phase != 0));
    check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    check("rsp_data",  rsp_data,       m_rsp_data);
    check("rsp_id",    32'(rsp_id),    32'(m_rsp_id));
    check("sh_d",      sh_d,           m_sh_d);
    check("sh_s",      32'(sh_s),      32'(m_sh_s));
    check("sh_lnr",    32'(sh_lnr),    32'(m_sh_lnr));
`ifdef SHIFT_ARB_PERF_EN
    for (int i = 0; i < NREQ; i++) check("perf_cnt", 32'(perf_cnt[16*i +: 16]), 32'(m_cnt[i]));
`endif
    @(posedge CLK);
    if (m_phase == 0) begin
      if (w >= 0) begin
        m_sh_d      = rd[w];
        m_sh_s      = rs[w];
        m_sh_lnr    = rl[w];
        m_pend_data = rl[w] ? (rd[w] << rs[w]) : (rd[w] >> rs[w]);
        m_pend_id   = w;
        m_ptr       = (w + 1) % NREQ;
        if (m_cnt[w] < 65535) m_cnt[w]++;
        m_phase     = 1;
        rv[w]       = 1'b0;
      end
    end else if (m_phase == 1) begin
      m_rsp_valid = 1'b1;
      m_rsp_data  = m_pend_data;
      m_rsp_id    = m_pend_id;
      m_phase     = 2;
    end else begin
      if (rr_b) begin
        m_rsp_valid = 1'b0;
        m_phase     = 0;
      end
    end
    last_w = w;
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    drive_inputs();
    RST = 1'b0;
    #1;
    model_reset();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_sh_d",      sh_d,           32'd0);
    check("rst_rsp_data",  rsp_data,       32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
    drive_inputs();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] s, input bit l);
    rv[i] = 1'b1;
    rd[i] = d;
    rs[i] = s;
    rl[i] = l;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_grants;
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0;
      rd[i] = 32'd0;
      rs[i] = 5'd0;
      rl[i] = 1'b0;
    end
    rr_b = 1'b1;
    RST  = 1'b1;
    model_reset();
    #3;
    do_reset();

    // Single left shift from requester 0.
    set_req(0, 32'h0000_0001, 5'd2, 1'b1);
    tick();
    check("single_ready", 32'(obs_ready), 32'h1);
    tick();
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_data",  rsp_data,       32'h0000_0004);
    check("single_id",    32'(rsp_id),    32'd0);
    tick();

    // Right shift from requester 2.
    set_req(2, 32'hffff_ffff, 5'd5, 1'b0);
    tick();
    tick();
    check("right_data", rsp_data,    32'h07ff_ffff);
    check("right_id",   32'(rsp_id), 32'd2);
    tick();

    // Fairness: all requesters valid continuously.
    do_reset();
    rr_b = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h9078_af1b, 5'(i + 1), bit'(i % 2));
    n_grants = 0;
    for (int c = 0; c < 30 && n_grants < 5; c++) begin
      tick();
      if (last_w >= 0) begin
        check("rr_order", 32'(obs_ready), 32'(1 << (n_grants % NREQ)));
        n_grants++;
        rv[last_w] = 1'b1;
      end
    end
    check("rr_count", 32'(n_grants), 32'd5);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
      tick();
    end

    // Backpressure with requester 1 waiting.
    rr_b = 1'b0;
    set_req(0, 32'h0000_00f0, 5'd3, 1'b0);
    tick();
    tick();
    set_req(1, 32'h8000_0001, 5'd31, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_data",  rsp_data,          32'h0000_001e);
      check("bp_id",    32'(rsp_id),       32'd0);
      check("bp_ready", 32'(obs_ready),    32'd0);
    end
    rr_b = 1'b1;
    tick();
    check("bp_release", 32'(rsp_valid), 32'd0);
    tick();
    check("bp_regrant", 32'(obs_ready), 32'h2);
    tick();
    check("bp_r1_data", rsp_data,    32'h8000_0000);
    check("bp_r1_id",   32'(rsp_id), 32'd1);

    // Reset while the response is held; pointer must return to 0.
    rr_b = 1'b0;
    tick();
    set_req(0, 32'h0000_0003, 5'd1, 1'b1);
    set_req(3, 32'h0000_0005, 5'd1, 1'b0);
    do_reset();
    set_req(0, 32'h0000_0003, 5'd1, 1'b1);
    set_req(3, 32'h0000_0005, 5'd1, 1'b0);
    rr_b = 1'b1;
    tick();
    check("rst_ptr0", 32'(obs_ready), 32'h1);
    for (int c = 0; c < 6; c++) tick();

`ifdef SHIFT_ARB_PERF_EN
    // Three grants to requester 1 after a fresh reset.
    do_reset();
    rr_b = 1'b1;
    for (int g = 0; g < 3; g++) begin
      set_req(1, 32'h0000_0100, 5'd4, 1'b0);
      tick();
      tick();
      tick();
    end
    check("perf_req1", 32'(perf_cnt[31:16]), 32'd3);
`endif

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, $urandom, 5'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));
        end else if ($urandom_range(0, 15) == 0) begin
          rv[i] = 1'b0;
        end
      end
      rr_b = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external BARREL_SHIFTER32 datapath between NREQ requesters (ALU, address unit, etc.).
- Each requester uses a valid/ready handshake to submit {data, amount, direction}.
- The block registers the winning operands onto the shifter inputs, captures the shifter output one cycle later, and holds a tagged response until it is accepted.
- Sits between the datapath requesters and the single shifter instance.

Parameters:
- NREQ, 4, number of requesters (2..4).
- IDW, 2, response tag width; must satisfy 2**IDW >= NREQ.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  request pending, one bit per requester.
- req_ready  output  NREQ  request accepted this cycle; one-hot or zero.
- req_data  input  NREQ*32  operand D; requester i occupies bits [32i+31:32i].
- req_amt  input  NREQ*5  shift amount S; requester i occupies bits [5i+4:5i].
- req_lnr  input  NREQ  direction: 1=left, 0=right.
- sh_d  output  32  to shifter D.
- sh_s  output  5  to shifter S.
- sh_lnr  output  1  to shifter LnR.
- sh_y  input  32  from shifter Y; combinational.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  32  shifted result.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; rr pointer=0, so requester 0 has highest priority.
  - sh_d=0, sh_s=0, sh_lnr=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0; req_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. The winner is the first requester with valid set, searching from ptr upward with wrap-around.
  - req_ready[winner]=1 only in IDLE and only if some valid is set.
  - On the clock edge where an acceptance occurs:
    - latch the winner's data, amount and lnr into sh_d, sh_s, sh_lnr;
    - latch the winner's index into the id register;
    - ptr = (winner+1) mod NREQ;
    - go to EXEC.
  - If no valid is set, stay in IDLE; ptr is unchanged.
- EXEC (one cycle):
  - rsp_data <= sh_y; rsp_id <= id; rsp_valid <= 1; go to RESP.
  - All req_ready=0.
- RESP:
  - rsp_valid=1 and rsp_data/rsp_id are held stable until rsp_ready=1.
  - On the edge with rsp_ready=1: rsp_valid <= 0, go to IDLE.
  - There is no same-cycle re-grant in RESP.
- Latency and throughput:
  - Acceptance at edge N gives rsp_valid high after edge N+1.
  - Minimum 3 cycles per operation when rsp_ready is tied high.
- sh_* hold their last value outside acceptance edges, to avoid shifter toggling.
- Requester rules:
  - A requester must keep valid and its operands stable until it sees ready.
  - Dropping valid before ready is legal; that request is simply never granted.
- Width rules:
  - S is a 5-bit amount (0..31) and is passed through unmodified.
  - Shifts are logical with zero fill; the shifter defines that, this block does not alter it.
- Boundary conditions:
  - Requester indices >= NREQ do not exist; ptr wraps NREQ-1 -> 0.
  - All requesters valid: strict rotation 0,1,2,3,0…
  - Reset asserted mid-EXEC or mid-RESP: the in-flight result is discarded, rsp_valid drops immediately, and no req_ready is issued for the lost operation.
  - rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
- Macro: SHIFT_ARB_PERF_EN.
- With the macro defined:
  - adds output perf_cnt, NREQ*16 bits: per-requester 16-bit grant counters;
  - each counter increments on its requester's acceptance edge and saturates at 16'hFFFF;
  - counters reset to 0 on RST.
- Without the macro: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/include (alongside prj_definition.v) holds:
  - state encodings ARB_IDLE=2'd0, ARB_EXEC=2'd1, ARB_RESP=2'd2;
  - `SHIFT_DATA_W=32 and `SHIFT_AMT_W=5.
- One sub-module: rr_arbiter_nreq.
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; the pointer register lives in shifter_arbiter.

Test Plan:
- Single request: req0 with D=32'h00000001, S=2, LnR=1, rsp_ready=1 -> req_ready[0] for 1 cycle; next cycle rsp_valid=1, rsp_data=32'h00000004, rsp_id=0.
- Right shift: req2 with D=32'hffffffff, S=5, LnR=0 -> rsp_data=32'h07ffffff, rsp_id=2.
- Fairness: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each response's rsp_id matches its grant; requester i's operands D=32'h9078af1b, S=i+1, LnR=i[0] (LnR=1 left) -> rsp_data = D shifted accordingly.
- Backpressure: rsp_ready=0 for 5 cycles with req1 waiting -> rsp_data/rsp_id stable, req_ready=0 throughout; then rsp_ready=1 -> return to IDLE, req1 granted next cycle.
- Reset mid-RESP: RST low while rsp_valid=1 -> rsp_valid=0 and busy=0 immediately (asynchronous); after release, ptr=0, so req0 wins over req3.
- With SHIFT_ARB_PERF_EN: 3 grants to req1 -> perf_cnt[31:16]=3; preload to 16'hFFFF then grant -> stays 16'hFFFF.
